// File: rtl/etap_tap_ctrl_pkg.sv
// EJTAG TAP controller shared definitions: TAP state codes, IR opcodes,
// DR select values and the IR -> DR select decode.
package etap_tap_ctrl_pkg;

    localparam int ETAP_IR_W = 5;

    // IEEE 1149.1 informative state encoding
    typedef enum logic [3:0] {
        ST_EXIT2_DR = 4'h0,
        ST_EXIT1_DR = 4'h1,
        ST_SHIFT_DR = 4'h2,
        ST_PAUSE_DR = 4'h3,
        ST_SEL_IR   = 4'h4,
        ST_UPD_DR   = 4'h5,
        ST_CAP_DR   = 4'h6,
        ST_SEL_DR   = 4'h7,
        ST_EXIT2_IR = 4'h8,
        ST_EXIT1_IR = 4'h9,
        ST_SHIFT_IR = 4'hA,
        ST_PAUSE_IR = 4'hB,
        ST_RTI      = 4'hC,
        ST_UPD_IR   = 4'hD,
        ST_CAP_IR   = 4'hE,
        ST_TLR      = 4'hF
    } tap_state_e;

    localparam logic [ETAP_IR_W-1:0] IR_IDCODE         = 5'h01;
    localparam logic [ETAP_IR_W-1:0] IR_SAMPLE_PRELOAD = 5'h02;
    localparam logic [ETAP_IR_W-1:0] IR_IMPCODE        = 5'h03;
    localparam logic [ETAP_IR_W-1:0] IR_ADDRESS        = 5'h08;
    localparam logic [ETAP_IR_W-1:0] IR_DATA           = 5'h09;
    localparam logic [ETAP_IR_W-1:0] IR_CONTROL        = 5'h0A;
    localparam logic [ETAP_IR_W-1:0] IR_EJTAGBOOT      = 5'h0C;
    localparam logic [ETAP_IR_W-1:0] IR_BYPASS         = 5'h1F;
    localparam logic [ETAP_IR_W-1:0] IR_RESET          = IR_IDCODE;

    localparam logic [3:0] SEL_ETAP_IDCODE    = 4'd0;
    localparam logic [3:0] SEL_ETAP_IMPCODE   = 4'd1;
    localparam logic [3:0] SEL_ETAP_ADDRESS   = 4'd2;
    localparam logic [3:0] SEL_ETAP_DATA      = 4'd3;
    localparam logic [3:0] SEL_ETAP_CONTROL   = 4'd4;
    localparam logic [3:0] SEL_ETAP_EJTAGBOOT = 4'd5;
    localparam logic [3:0] SEL_ETAP_SAMPLE    = 4'd6;
    localparam logic [3:0] SEL_ETAP_BYPASS    = 4'd7;

    // Unknown opcodes fall through to BYPASS so an unsupported IR never
    // leaves a dangling DR selected.
    function automatic logic [3:0] ir_decode(input logic [ETAP_IR_W-1:0] op);
        case (op)
            IR_IDCODE:         ir_decode = SEL_ETAP_IDCODE;
            IR_IMPCODE:        ir_decode = SEL_ETAP_IMPCODE;
            IR_ADDRESS:        ir_decode = SEL_ETAP_ADDRESS;
            IR_DATA:           ir_decode = SEL_ETAP_DATA;
            IR_CONTROL:        ir_decode = SEL_ETAP_CONTROL;
            IR_EJTAGBOOT:      ir_decode = SEL_ETAP_EJTAGBOOT;
            IR_SAMPLE_PRELOAD: ir_decode = SEL_ETAP_SAMPLE;
            IR_BYPASS:         ir_decode = SEL_ETAP_BYPASS;
            default:           ir_decode = SEL_ETAP_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/etap_tap_ctrl_tck_sync.sv
// Synchronizes the asynchronous JTAG pins into the clk domain and turns the
// TCK level into single-cycle rise/fall pulses. TMS/TDI come out of chains of
// the same depth so they line up with the TCK edge they belong to.
module etap_tap_ctrl_tck_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s
);

    logic [SYNC_STG-1:0] tck_q;
    logic [SYNC_STG-1:0] tms_q;
    logic [SYNC_STG-1:0] tdi_q;
    logic                tck_last_q;

    // Synchronizer chains plus one history flop for TCK edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_q      <= '0;
            tms_q      <= '0;
            tdi_q      <= '0;
            tck_last_q <= 1'b0;
        end else begin
            tck_q      <= {tck_q[SYNC_STG-2:0], tck};
            tms_q      <= {tms_q[SYNC_STG-2:0], tms};
            tdi_q      <= {tdi_q[SYNC_STG-2:0], tdi};
            tck_last_q <= tck_q[SYNC_STG-1];
        end
    end

    // Rise has priority, so the two pulses can never be seen together
    assign tck_rise = tck_q[SYNC_STG-1] & ~tck_last_q;
    assign tck_fall = ~tck_q[SYNC_STG-1] & tck_last_q & ~tck_rise;
    assign tms_s    = tms_q[SYNC_STG-1];
    assign tdi_s    = tdi_q[SYNC_STG-1];

endmodule

// File: rtl/etap_tap_ctrl.sv
// EJTAG TAP controller oversampled on the system clock. Runs the 1149.1 TAP
// FSM on synchronized TCK edges, holds the IR, decodes the DR select and
// drives the shift/capture/update strobes toward the DR mux.
module etap_tap_ctrl #(
    parameter int IR_W     = 5,
    parameter int SYNC_STG = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tck,
    input  logic            tms,
    input  logic            tdi,
    output logic            tdo,
    output logic            tdo_oe,
    input  logic            s_data_out,
    output logic [3:0]      sel,
    output logic            shift_dr,
    output logic            clk_dr,
    output logic            update_dr,
    output logic [IR_W-1:0] ir,
    output logic [3:0]      tap_state
);
    import etap_tap_ctrl_pkg::*;

    localparam logic [IR_W-1:0] IR_RST     = IR_W'(IR_RESET);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

    logic tck_rise, tck_fall, tms_s, tdi_s;

    tap_state_e      state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [IR_W-1:0] ir_sh_q, ir_sh_d;
    logic [3:0]      sel_q, sel_d;
    logic            tdo_q, tdo_d;
    logic            tdo_oe_q, tdo_oe_d;
    logic            shift_dr_q, shift_dr_d;
    logic            clk_dr_q, clk_dr_d;
    logic            update_dr_q, update_dr_d;

    etap_tap_ctrl_tck_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s)
    );

    // TAP next-state: moves only on a synchronized TCK rise
    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                ST_TLR:      state_d = tms_s ? ST_TLR      : ST_RTI;
                ST_RTI:      state_d = tms_s ? ST_SEL_DR   : ST_RTI;
                ST_SEL_DR:   state_d = tms_s ? ST_SEL_IR   : ST_CAP_DR;
                ST_CAP_DR:   state_d = tms_s ? ST_EXIT1_DR : ST_SHIFT_DR;
                ST_SHIFT_DR: state_d = tms_s ? ST_EXIT1_DR : ST_SHIFT_DR;
                ST_EXIT1_DR: state_d = tms_s ? ST_UPD_DR   : ST_PAUSE_DR;
                ST_PAUSE_DR: state_d = tms_s ? ST_EXIT2_DR : ST_PAUSE_DR;
                ST_EXIT2_DR: state_d = tms_s ? ST_UPD_DR   : ST_SHIFT_DR;
                ST_UPD_DR:   state_d = tms_s ? ST_SEL_DR   : ST_RTI;
                ST_SEL_IR:   state_d = tms_s ? ST_TLR      : ST_CAP_IR;
                ST_CAP_IR:   state_d = tms_s ? ST_EXIT1_IR : ST_SHIFT_IR;
                ST_SHIFT_IR: state_d = tms_s ? ST_EXIT1_IR : ST_SHIFT_IR;
                ST_EXIT1_IR: state_d = tms_s ? ST_UPD_IR   : ST_PAUSE_IR;
                ST_PAUSE_IR: state_d = tms_s ? ST_EXIT2_IR : ST_PAUSE_IR;
                ST_EXIT2_IR: state_d = tms_s ? ST_UPD_IR   : ST_SHIFT_IR;
                ST_UPD_IR:   state_d = tms_s ? ST_SEL_DR   : ST_RTI;
                default:     state_d = ST_TLR;
            endcase
        end
    end

    // Datapath next values: rise acts on the state being left, fall on the
    // state just entered (update, TDO launch)
    always_comb begin
        ir_d        = ir_q;
        ir_sh_d     = ir_sh_q;
        sel_d       = ir_decode(ETAP_IR_W'(ir_q));
        tdo_d       = tdo_q;
        tdo_oe_d    = tdo_oe_q;
        shift_dr_d  = shift_dr_q;
        clk_dr_d    = 1'b0;
        update_dr_d = 1'b0;
        if (tck_rise) begin
            // shift_dr tags which kind of step this clk_dr is for
            clk_dr_d   = (state_q == ST_CAP_DR) || (state_q == ST_SHIFT_DR);
            shift_dr_d = (state_q == ST_SHIFT_DR);
            if (state_q == ST_CAP_IR) begin
                ir_sh_d = IR_CAPTURE;
            end else if (state_q == ST_SHIFT_IR) begin
                ir_sh_d = {tdi_s, ir_sh_q[IR_W-1:1]};
            end
        end else if (tck_fall) begin
            update_dr_d = (state_q == ST_UPD_DR);
            if (state_q == ST_UPD_IR) begin
                ir_d = ir_sh_q;
            end
            if (state_q == ST_SHIFT_DR) begin
                tdo_d = s_data_out;
            end else if (state_q == ST_SHIFT_IR) begin
                tdo_d = ir_sh_q[0];
            end
            tdo_oe_d = (state_q == ST_SHIFT_DR) || (state_q == ST_SHIFT_IR);
        end
        // Held in IDCODE for as long as the TAP sits in reset
        if (state_q == ST_TLR) begin
            ir_d = IR_RST;
        end
    end

    // State and output registers; reset aborts any scan without an update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_TLR;
            ir_q        <= IR_RST;
            ir_sh_q     <= '0;
            sel_q       <= SEL_ETAP_IDCODE;
            tdo_q       <= 1'b0;
            tdo_oe_q    <= 1'b0;
            shift_dr_q  <= 1'b0;
            clk_dr_q    <= 1'b0;
            update_dr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_sh_q     <= ir_sh_d;
            sel_q       <= sel_d;
            tdo_q       <= tdo_d;
            tdo_oe_q    <= tdo_oe_d;
            shift_dr_q  <= shift_dr_d;
            clk_dr_q    <= clk_dr_d;
            update_dr_q <= update_dr_d;
        end
    end

    assign tdo       = tdo_q;
    assign tdo_oe    = tdo_oe_q;
    assign sel       = sel_q;
    assign shift_dr  = shift_dr_q;
    assign clk_dr    = clk_dr_q;
    assign update_dr = update_dr_q;
    assign ir        = ir_q;
    assign tap_state = state_q;

endmodule

// File: tb/tb_etap_tap_ctrl.sv
// Bench for etap_tap_ctrl: TCK = clk/8, pins driven while TCK is low, and a
// table-driven TAP model predicting state, IR, select, TDO and strobe counts.
module tb_etap_tap_ctrl;
    import etap_tap_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tck = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       s_data_out = 1'b0;
    logic       tdo, tdo_oe, shift_dr, clk_dr, update_dr;
    logic [3:0] sel, tap_state;
    logic [4:0] ir;

    etap_tap_ctrl #(.IR_W(5), .SYNC_STG(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tck        (tck),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_oe     (tdo_oe),
        .s_data_out (s_data_out),
        .sel        (sel),
        .shift_dr   (shift_dr),
        .clk_dr     (clk_dr),
        .update_dr  (update_dr),
        .ir         (ir),
        .tap_state  (tap_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed strobe counts (each clk a strobe is high counts once)
    int n_cap = 0, n_sh = 0, n_upd = 0;
    always @(negedge clk) begin
        if (clk_dr && !shift_dr) n_cap++;
        if (clk_dr && shift_dr)  n_sh++;
        if (update_dr)           n_upd++;
    end

    // Reference model
    logic [3:0] nxt [16][2];
    logic [3:0] m_st;
    logic [4:0] m_ir, m_sh;
    logic       m_tdo, m_oe, m_shdr, m_sdo;
    int         e_cap = 0, e_sh = 0, e_upd = 0;

    function automatic logic [3:0] exp_sel(input logic [4:0] op);
        case (op)
            5'h01:   return 4'd0;
            5'h03:   return 4'd1;
            5'h08:   return 4'd2;
            5'h09:   return 4'd3;
            5'h0A:   return 4'd4;
            5'h0C:   return 4'd5;
            5'h02:   return 4'd6;
            default: return 4'd7;
        endcase
    endfunction

    task automatic set_tr(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
        nxt[s][0] = n0;
        nxt[s][1] = n1;
    endtask

    task automatic model_reset();
        m_st = ST_TLR; m_ir = 5'h01; m_sh = 5'h00;
        m_tdo = 1'b0; m_oe = 1'b0; m_shdr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("tap_state", 32'(tap_state), 32'(m_st));
        chk("ir", 32'(ir), 32'(m_ir));
        chk("sel", 32'(sel), 32'(exp_sel(m_ir)));
        chk("tdo", 32'(tdo), 32'(m_tdo));
        chk("tdo_oe", 32'(tdo_oe), 32'(m_oe));
        chk("shift_dr", 32'(shift_dr), 32'(m_shdr));
        chk("capture_count", 32'(n_cap), 32'(e_cap));
        chk("shift_count", 32'(n_sh), 32'(e_sh));
        chk("update_count", 32'(n_upd), 32'(e_upd));
    endtask

    // One TCK period: pins set while low, check, rise, wait, fall
    task automatic tick(input logic t_ms, input logic t_di, output logic seen);
        tms = t_ms;
        tdi = t_di;
        repeat (4) @(posedge clk);
        @(negedge clk);
        seen = tdo;
        check_all();
        if (m_st == ST_CAP_DR)   e_cap++;
        if (m_st == ST_SHIFT_DR) e_sh++;
        m_shdr = (m_st == ST_SHIFT_DR);
        if (m_st == ST_CAP_IR)        m_sh = 5'h01;
        else if (m_st == ST_SHIFT_IR) m_sh = {t_di, m_sh[4:1]};
        m_st = nxt[m_st][t_ms];
        m_sdo = 1'($urandom_range(0, 1));
        s_data_out = m_sdo;
        tck = 1'b1;
        repeat (4) @(negedge clk);
        if (m_st == ST_UPD_DR) e_upd++;
        if (m_st == ST_UPD_IR) m_ir = m_sh;
        if (m_st == ST_SHIFT_DR)      m_tdo = m_sdo;
        else if (m_st == ST_SHIFT_IR) m_tdo = m_sh[0];
        m_oe = (m_st == ST_SHIFT_DR) || (m_st == ST_SHIFT_IR);
        if (m_st == ST_TLR) m_ir = 5'h01;
        tck = 1'b0;
    endtask

    task automatic step(input logic t_ms, input logic t_di);
        logic t;
        tick(t_ms, t_di, t);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // From TLR/RTI: load val into IR, optionally leaving via Pause-IR
    task automatic ir_scan(input logic [4:0] val, input bit via_pause);
        logic       t;
        logic [4:0] got;
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, val[i], t);
            got[i] = t;
        end
        if (via_pause) begin
            step(0, 0); step(0, 0); step(1, 0); step(1, 0);
        end else begin
            step(1, 0);
        end
        step(0, 0);
        settle();
        chk("ir_capture_tdo", 32'(got), 32'h01);
    endtask

    // From TLR/RTI: n-bit DR scan ending in Run-Test/Idle
    task automatic dr_scan(input int n);
        int c0, s0, u0;
        c0 = n_cap; s0 = n_sh; u0 = n_upd;
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < n; i++) step(i == n - 1, 1'($urandom_range(0, 1)));
        step(1, 0); step(0, 0);
        settle();
        chk("dr_capture_pulses", 32'(n_cap - c0), 32'd1);
        chk("dr_shift_pulses", 32'(n_sh - s0), 32'(n));
        chk("dr_update_pulses", 32'(n_upd - u0), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        int u0;
        set_tr(ST_TLR,      ST_RTI,      ST_TLR);
        set_tr(ST_RTI,      ST_RTI,      ST_SEL_DR);
        set_tr(ST_SEL_DR,   ST_CAP_DR,   ST_SEL_IR);
        set_tr(ST_CAP_DR,   ST_SHIFT_DR, ST_EXIT1_DR);
        set_tr(ST_SHIFT_DR, ST_SHIFT_DR, ST_EXIT1_DR);
        set_tr(ST_EXIT1_DR, ST_PAUSE_DR, ST_UPD_DR);
        set_tr(ST_PAUSE_DR, ST_PAUSE_DR, ST_EXIT2_DR);
        set_tr(ST_EXIT2_DR, ST_SHIFT_DR, ST_UPD_DR);
        set_tr(ST_UPD_DR,   ST_RTI,      ST_SEL_DR);
        set_tr(ST_SEL_IR,   ST_CAP_IR,   ST_TLR);
        set_tr(ST_CAP_IR,   ST_SHIFT_IR, ST_EXIT1_IR);
        set_tr(ST_SHIFT_IR, ST_SHIFT_IR, ST_EXIT1_IR);
        set_tr(ST_EXIT1_IR, ST_PAUSE_IR, ST_UPD_IR);
        set_tr(ST_PAUSE_IR, ST_PAUSE_IR, ST_EXIT2_IR);
        set_tr(ST_EXIT2_IR, ST_SHIFT_IR, ST_UPD_IR);
        set_tr(ST_UPD_IR,   ST_RTI,      ST_SEL_DR);
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        chk("rst_clk_dr", 32'(clk_dr), 32'd0);
        chk("rst_update_dr", 32'(update_dr), 32'd0);
        rst = 1'b0;

        // Five tms=1 rises land in Test-Logic-Reset
        for (int i = 0; i < 5; i++) step(1, 0);
        settle();

        // Load DATA and run a 32-bit DR scan through it
        ir_scan(5'h09, 0);
        chk("ir_data", 32'(ir), 32'h09);
        chk("sel_data", 32'(sel), 32'd3);
        dr_scan(32);
        chk("sel_stable_dr", 32'(sel), 32'd3);

        // Unknown opcodes select BYPASS
        ir_scan(5'h1F, 0);
        chk("sel_1f", 32'(sel), 32'd7);
        ir_scan(5'h15, 0);
        chk("sel_15", 32'(sel), 32'd7);
        dr_scan(1);

        // Reset in the middle of a DR shift
        u0 = n_upd;
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 10; i++) step(0, 1'($urandom_range(0, 1)));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_state", 32'(tap_state), 32'(ST_TLR));
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_ir", 32'(ir), 32'h01);
        chk("midrst_shift_dr", 32'(shift_dr), 32'd0);
        chk("midrst_tdo_oe", 32'(tdo_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1, 0); step(1, 0);
        settle();
        chk("midrst_no_update", 32'(n_upd - u0), 32'd0);

        // IR load leaving through Pause-IR
        ir_scan(5'h08, 1);
        chk("ir_address", 32'(ir), 32'h08);
        chk("sel_address", 32'(sel), 32'd2);

        // Random TMS/TDI walk against the model
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) step(1, 0);
        settle();
        chk("final_tlr", 32'(tap_state), 32'(ST_TLR));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
